omsp_spm_cmd_sequencer: RTL

- Sequences SM management commands (protect, unprotect, verify) from the execution unit into the SPM array control.
- Issues the single-cycle update_spm/enable_spm/verify_spm strobes and samples the resulting violation.
- After a successful protect, streams the freshly derived key words from the key-derivation unit into the new SM via write_key/key_in/key_idx.
- Sits between the execution unit's SM instruction decoder and the SPM array control; reports busy, done and status back to the execution unit.

---
 rtl/omsp_spm_cmd_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/omsp_spm_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// omsp_spm_cmd_sequencer
//   Sequences SM management commands (protect / unprotect / verify) from the
//   execution unit into the SPM array control.  Issues the single-cycle
//   update/verify strobes, samples the returned violation and, after a
//   successful protect, streams the freshly derived key words into the new SM.
//
// Ports
//   mclk, puc_rst                    clock, synchronous active-high reset
//   cmd_valid, cmd_op, cmd_ready     command handshake (op: 00 prot, 01 unprot,
//                                    10 verify, 11 illegal)
//   violation_in                     violation from the SPM array control
//   key_word_valid, key_word,
//   key_word_ready                   key-derivation beat handshake
//   update_spm, enable_spm,
//   verify_spm                       strobes to the SPM array control
//   write_key, key_in, key_idx       key word write port into the SM
//   busy, done, status               progress/result back to the exec unit
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one-cycle update/verify strobe for the latched op
// CHECK | sample violation_in from the SPM array control
// KEY   | accept key words from the key-derivation unit, watch timeout
// DONE  | one-cycle done pulse, status valid
// ----------------------------------------------------------------------------
module omsp_spm_cmd_sequencer #(
  parameter int KEY_WORDS    = 4,
  parameter int KEY_IDX_SIZE = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_op,
  output logic                    cmd_ready,
  input  logic                    violation_in,
  input  logic                    key_word_valid,
  input  logic [15:0]             key_word,
  output logic                    key_word_ready,
  output logic                    update_spm,
  output logic                    enable_spm,
  output logic                    verify_spm,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              status
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);
  localparam logic [TO_W-1:0]         TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]         TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_PROTECT   = 2'b00;
  localparam logic [1:0] OP_UNPROTECT = 2'b01;
  localparam logic [1:0] OP_VERIFY    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL   = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_VIOLATION = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_ILLEGAL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CHECK = 3'd2,
    S_KEY   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              op_q, op_nxt;
  logic [1:0]              status_q, status_nxt;
  logic [KEY_IDX_SIZE-1:0] word_cnt, word_cnt_nxt;
  logic [TO_W-1:0]         to_cnt, to_cnt_nxt;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state    <= S_IDLE;
      op_q     <= OP_PROTECT;
      status_q <= ST_OK;
      word_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      status_q <= status_nxt;
      word_cnt <= word_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_nxt         = op_q;
    status_nxt     = status_q;
    word_cnt_nxt   = word_cnt;
    to_cnt_nxt     = to_cnt;
    cmd_ready      = 1'b0;
    key_word_ready = 1'b0;
    update_spm     = 1'b0;
    enable_spm     = 1'b0;
    verify_spm     = 1'b0;
    write_key      = 1'b0;
    key_in         = 16'h0000;
    key_idx        = '0;
    done           = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_nxt = cmd_op;
          if (cmd_op == OP_ILLEGAL) begin
            state_nxt  = S_DONE;
            status_nxt = ST_ILLEGAL;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        case (op_q)
          OP_PROTECT: begin
            update_spm = 1'b1;
            enable_spm = 1'b1;
            state_nxt  = S_CHECK;
          end
          OP_UNPROTECT: begin
            update_spm = 1'b1;
            state_nxt  = S_DONE;
            status_nxt = ST_OK;
          end
          OP_VERIFY: begin
            verify_spm = 1'b1;
            state_nxt  = S_CHECK;
          end
          default: begin
            state_nxt  = S_DONE;
            status_nxt = ST_ILLEGAL;
          end
        endcase
      end

      S_CHECK: begin
        if (violation_in) begin
          state_nxt  = S_DONE;
          status_nxt = ST_VIOLATION;
        end else if (op_q == OP_PROTECT) begin
          state_nxt    = S_KEY;
          word_cnt_nxt = '0;
          to_cnt_nxt   = '0;
        end else begin
          state_nxt  = S_DONE;
          status_nxt = ST_OK;
        end
      end

      S_KEY: begin
        key_word_ready = 1'b1;
        // A beat always wins over an expiring timeout in the same cycle.
        if (key_word_valid) begin
          write_key  = 1'b1;
          key_in     = key_word;
          key_idx    = word_cnt;
          to_cnt_nxt = '0;
          if (word_cnt == LAST_IDX) begin
            state_nxt  = S_DONE;
            status_nxt = ST_OK;
          end else if (word_cnt != '1) begin
            word_cnt_nxt = word_cnt + KEY_IDX_SIZE'(1);
          end
        end else begin
          if (to_cnt != TO_MAX) to_cnt_nxt = to_cnt + TO_W'(1);
          // This idle cycle brings the counter to TIMEOUT.
          if (to_cnt == TO_LAST) begin
            state_nxt  = S_DONE;
            status_nxt = ST_TIMEOUT;
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign status = status_q;

endmodule
